// File: rtl/q_pkg.sv
// Shared constants, FSM state encoding and Q-table row slot helpers
// for the Q-table update path.
package q_pkg;

   localparam int Q_W       = 18;
   localparam int Q_FRAC    = 8;
   localparam int N_ACTIONS = 9;
   localparam int S_W       = 15;
   localparam int ROW_W     = 162;
   localparam int A_W       = 4;
   localparam int CALC_W    = 20;

   localparam logic signed [Q_W-1:0] Q_ONE = Q_W'(1 << Q_FRAC);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_NXT,
      ST_WT_NXT,
      ST_MAX,
      ST_RD_CUR,
      ST_WT_CUR,
      ST_CALC,
      ST_WR
   } q_state_e;

   // Slot indices outside 0..N_ACTIONS-1 read as zero.
   function automatic logic [Q_W-1:0] row_slot_get(
      input logic [ROW_W-1:0] row,
      input logic [A_W-1:0]   idx
   );
      logic [Q_W-1:0] slot;
      slot = '0;
      for (int k = 0; k < N_ACTIONS; k++) begin
         if (idx == A_W'(k)) slot = row[k*Q_W +: Q_W];
      end
      return slot;
   endfunction

   // Slot indices outside 0..N_ACTIONS-1 leave the row unchanged.
   function automatic logic [ROW_W-1:0] row_slot_set(
      input logic [ROW_W-1:0] row,
      input logic [A_W-1:0]   idx,
      input logic [Q_W-1:0]   val
   );
      logic [ROW_W-1:0] r;
      r = row;
      for (int k = 0; k < N_ACTIONS; k++) begin
         if (idx == A_W'(k)) r[k*Q_W +: Q_W] = val;
      end
      return r;
   endfunction

endpackage

// File: rtl/q_update_if.sv
// Request/response handshake with the reward controller plus the
// single-port Q-table RAM bus, bundled for the q_update block.
interface q_update_if;
   import q_pkg::*;

   logic                    start;
   logic [S_W-1:0]          s_cur;
   logic [S_W-1:0]          s_next;
   logic [A_W-1:0]          action;
   logic signed [Q_W-1:0]   reward;
   logic                    terminal;

   logic [S_W-1:0]          mem_addr;
   logic                    mem_rd_en;
   logic [ROW_W-1:0]        mem_rd_data;
   logic                    mem_wr_en;
   logic [ROW_W-1:0]        mem_wr_data;

   logic                    busy;
   logic                    done;
   logic                    err;
   logic signed [Q_W-1:0]   q_new;

   modport master (
      output start, s_cur, s_next, action, reward, terminal, mem_rd_data,
      input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
      input  busy, done, err, q_new
   );

   modport slave (
      input  start, s_cur, s_next, action, reward, terminal, mem_rd_data,
      output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
      output busy, done, err, q_new
   );

endinterface

// File: rtl/q_row_max_seq.sv
// Sequential signed maximum over the 9 slots of a Q-table row, one slot
// per cycle; the row is loaded on start and shifted down each cycle.
module q_row_max_seq
   import q_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ROW_W-1:0]      row,
   output logic signed [Q_W-1:0] max,
   output logic                  valid
);

   logic [ROW_W-1:0]      row_q, row_d;
   logic [3:0]            cnt_q, cnt_d;
   logic signed [Q_W-1:0] max_q, max_d;
   logic                  valid_q, valid_d;
   logic signed [Q_W-1:0] slot;

   always_comb begin
      row_d   = row_q;
      cnt_d   = cnt_q;
      max_d   = max_q;
      valid_d = valid_q;
      slot    = row_q[Q_W-1:0];
      if (start) begin
         row_d   = row;
         cnt_d   = 4'(N_ACTIONS);
         valid_d = 1'b0;
      end else if (cnt_q != '0) begin
         // first slot seeds the running max regardless of its value
         if ((cnt_q == 4'(N_ACTIONS)) || (slot > max_q)) max_d = slot;
         row_d = row_q >> Q_W;
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_q   <= '0;
         cnt_q   <= '0;
         max_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         row_q   <= row_d;
         cnt_q   <= cnt_d;
         max_q   <= max_d;
         valid_q <= valid_d;
      end
   end

   assign max   = max_q;
   assign valid = valid_q;

endmodule

// File: rtl/q_update.sv
// Q-table writer: Q(s,a) += 2^-ALPHA_SHIFT * (r + gamma*maxQ' - Q), row read-modify-write.
// Q_UPDATE_SAT_EN defined: result saturates to 18 bits; undefined: result wraps.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start; inputs latched on acceptance
// RD_NXT   | read strobe to s_next row
// WT_NXT   | next-state row on read bus, handed to max scanner
// MAX      | 9 cycles of signed max scan over the next-state row
// RD_CUR   | read strobe to s_cur row
// WT_CUR   | current row captured, q_old extracted
// CALC     | TD update computed and registered, write data prepared
// WR       | write strobe to s_cur row (suppressed for invalid action)
module q_update
   import q_pkg::*;
#(
   parameter int ALPHA_SHIFT = 2,
   parameter int GAMMA_SHIFT = 3
)(
   input  logic      clk,
   input  logic      rst,
   q_update_if.slave bus
);

   q_state_e              state_q, state_d;
   logic [3:0]            max_cnt_q, max_cnt_d;
   logic [S_W-1:0]        s_cur_q, s_cur_d;
   logic [S_W-1:0]        s_next_q, s_next_d;
   logic [A_W-1:0]        action_q, action_d;
   logic signed [Q_W-1:0] reward_q, reward_d;
   logic                  terminal_q, terminal_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic signed [Q_W-1:0] q_old_q, q_old_d;
   logic signed [Q_W-1:0] q_calc_q, q_calc_d;
   logic [S_W-1:0]        mem_addr_q, mem_addr_d;
   logic                  rd_en_q, rd_en_d;
   logic                  wr_en_q, wr_en_d;
   logic [ROW_W-1:0]      wr_data_q, wr_data_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic signed [Q_W-1:0] q_new_q, q_new_d;

   logic signed [Q_W-1:0]    scan_max;
   logic                     scan_valid;
   logic signed [CALC_W-1:0] m_x, gm_x, rew_x, qold_x, td_x, delta_x, sum_x;
   logic signed [Q_W-1:0]    sum_red;
   logic                     act_bad;

   function automatic logic signed [Q_W-1:0] reduce_sum(input logic signed [CALC_W-1:0] s);
`ifdef Q_UPDATE_SAT_EN
      localparam logic signed [CALC_W-1:0] SUM_HI = CALC_W'((1 << (Q_W-1)) - 1);
      localparam logic signed [CALC_W-1:0] SUM_LO = ~SUM_HI;
      if (s > SUM_HI)      return SUM_HI[Q_W-1:0];
      else if (s < SUM_LO) return SUM_LO[Q_W-1:0];
      else                 return s[Q_W-1:0];
`else
      return s[Q_W-1:0];
`endif
   endfunction

   q_row_max_seq u_max (
      .clk   (clk),
      .rst   (rst),
      .start (state_q == ST_WT_NXT),
      .row   (bus.mem_rd_data),
      .max   (scan_max),
      .valid (scan_valid)
   );

   assign act_bad = (action_q > A_W'(N_ACTIONS - 1));

   always_comb begin
      if (terminal_q || !scan_valid) m_x = '0;
      else                           m_x = CALC_W'(scan_max);
      rew_x   = CALC_W'(reward_q);
      qold_x  = CALC_W'(q_old_q);
      gm_x    = m_x - (m_x >>> GAMMA_SHIFT);
      td_x    = rew_x + gm_x - qold_x;
      delta_x = td_x >>> ALPHA_SHIFT;
      sum_x   = qold_x + delta_x;
      sum_red = reduce_sum(sum_x);
   end

   always_comb begin
      state_d    = state_q;
      max_cnt_d  = max_cnt_q;
      s_cur_d    = s_cur_q;
      s_next_d   = s_next_q;
      action_d   = action_q;
      reward_d   = reward_q;
      terminal_d = terminal_q;
      row_d      = row_q;
      q_old_d    = q_old_q;
      q_calc_d   = q_calc_q;
      mem_addr_d = mem_addr_q;
      wr_data_d  = wr_data_q;
      busy_d     = busy_q;
      q_new_d    = q_new_q;
      rd_en_d    = 1'b0;
      wr_en_d    = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               s_cur_d    = bus.s_cur;
               s_next_d   = bus.s_next;
               action_d   = bus.action;
               reward_d   = bus.reward;
               terminal_d = bus.terminal;
               busy_d     = 1'b1;
               rd_en_d    = 1'b1;
               if (bus.terminal) begin
                  state_d    = ST_RD_CUR;
                  mem_addr_d = bus.s_cur;
               end else begin
                  state_d    = ST_RD_NXT;
                  mem_addr_d = bus.s_next;
               end
            end
         end
         ST_RD_NXT: state_d = ST_WT_NXT;
         ST_WT_NXT: begin
            state_d   = ST_MAX;
            max_cnt_d = 4'(N_ACTIONS - 1);
         end
         ST_MAX: begin
            if (max_cnt_q == '0) begin
               state_d    = ST_RD_CUR;
               mem_addr_d = s_cur_q;
               rd_en_d    = 1'b1;
            end else begin
               max_cnt_d = max_cnt_q - 4'd1;
            end
         end
         ST_RD_CUR: state_d = ST_WT_CUR;
         ST_WT_CUR: begin
            row_d   = bus.mem_rd_data;
            q_old_d = row_slot_get(bus.mem_rd_data, action_q);
            state_d = ST_CALC;
         end
         ST_CALC: begin
            q_calc_d   = sum_red;
            wr_data_d  = row_slot_set(row_q, action_q, sum_red);
            mem_addr_d = s_cur_q;
            wr_en_d    = !act_bad;
            state_d    = ST_WR;
         end
         ST_WR: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = act_bad;
            q_new_d = q_calc_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         max_cnt_q  <= '0;
         s_cur_q    <= '0;
         s_next_q   <= '0;
         action_q   <= '0;
         reward_q   <= '0;
         terminal_q <= 1'b0;
         row_q      <= '0;
         q_old_q    <= '0;
         q_calc_q   <= '0;
         mem_addr_q <= '0;
         rd_en_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         q_new_q    <= '0;
      end else begin
         state_q    <= state_d;
         max_cnt_q  <= max_cnt_d;
         s_cur_q    <= s_cur_d;
         s_next_q   <= s_next_d;
         action_q   <= action_d;
         reward_q   <= reward_d;
         terminal_q <= terminal_d;
         row_q      <= row_d;
         q_old_q    <= q_old_d;
         q_calc_q   <= q_calc_d;
         mem_addr_q <= mem_addr_d;
         rd_en_q    <= rd_en_d;
         wr_en_q    <= wr_en_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         q_new_q    <= q_new_d;
      end
   end

   // Reset arriving during WR must still stop the RAM from committing the row.
   assign bus.mem_wr_en   = wr_en_q & ~rst;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_rd_en   = rd_en_q;
   assign bus.mem_wr_data = wr_data_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.err         = err_q;
   assign bus.q_new       = q_new_q;

endmodule

// File: tb/tb_q_update.sv
// Directed bench for q_update: row RAM model, cycle-exact latency, arithmetic
// and write-back checks, reset and busy behaviour.
module tb_q_update;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   q_update_if bus();

   q_update #(.ALPHA_SHIFT(2), .GAMMA_SHIFT(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [161:0] ram [16];
   logic         pre_en   = 1'b0;
   logic [3:0]   pre_addr = '0;
   logic [161:0] pre_data = '0;
   int           wr_total = 0;
   int           overlap  = 0;

   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_addr[3:0]];
      if (pre_en) ram[pre_addr] <= pre_data;
      else if (bus.mem_wr_en) begin
         ram[bus.mem_addr[3:0]] <= bus.mem_wr_data;
         wr_total <= wr_total + 1;
      end
      if (bus.mem_rd_en && bus.mem_wr_en) overlap <= overlap + 1;
   end

   function automatic logic [161:0] put(input logic [161:0] r, input int k, input int v);
      logic [161:0] t;
      t = r;
      t[18*k +: 18] = 18'(v);
      return t;
   endfunction

   function automatic logic [161:0] fill(input int v);
      logic [161:0] t;
      t = '0;
      for (int k = 0; k < 9; k++) t = put(t, k, v);
      return t;
   endfunction

   task automatic load_row(input int a, input logic [161:0] d);
      @(negedge clk);
      pre_addr = 4'(a);
      pre_data = d;
      pre_en   = 1'b1;
      @(negedge clk);
      pre_en   = 1'b0;
   endtask

   int                  o_done_c, o_busy_bad, o_rd_n, o_wr_n, o_wr_c;
   int                  o_rd_c [2];
   logic [14:0]         o_rd_a [2];
   logic [14:0]         o_wr_a;
   logic [161:0]        o_wr_d;
   logic signed [17:0]  o_q, o_q_mid;
   logic                o_err;

   // Accept edge is cycle 0; observations are taken at the negedge of each cycle.
   task automatic do_update(input bit now, input int sc, input int sn, input int act,
                            input int rw, input bit term, input int poke_c);
      if (!now) @(negedge clk);
      bus.s_cur    = 15'(sc);
      bus.s_next   = 15'(sn);
      bus.action   = 4'(act);
      bus.reward   = 18'(rw);
      bus.terminal = term;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.s_cur    = 15'd15;
      bus.s_next   = 15'd14;
      bus.action   = 4'd0;
      bus.reward   = -18'sd5000;
      bus.terminal = !term;
      o_done_c = -1; o_busy_bad = 0; o_rd_n = 0; o_wr_n = 0; o_wr_c = -1;
      o_rd_c[0] = -1; o_rd_c[1] = -1; o_rd_a[0] = '0; o_rd_a[1] = '0;
      o_wr_a = '0; o_wr_d = '0; o_q = '0; o_q_mid = '0; o_err = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 2) o_q_mid = bus.q_new;
         if (bus.mem_rd_en) begin
            if (o_rd_n < 2) begin
               o_rd_c[o_rd_n] = c;
               o_rd_a[o_rd_n] = bus.mem_addr;
            end
            o_rd_n++;
         end
         if (bus.mem_wr_en) begin
            o_wr_n++;
            o_wr_c = c;
            o_wr_a = bus.mem_addr;
            o_wr_d = bus.mem_wr_data;
         end
         if (bus.done) begin
            o_done_c = c;
            o_q      = bus.q_new;
            o_err    = bus.err;
            if (bus.busy) o_busy_bad++;
            break;
         end
         if (!bus.busy) o_busy_bad++;
         bus.start = (c == poke_c);
         @(negedge clk);
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
      checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL rst_done_err got %b%b exp 00", bus.done, bus.err); end
      checks++; if (bus.mem_rd_en !== 1'b0 || bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_strobes got %b%b exp 00", bus.mem_rd_en, bus.mem_wr_en); end
      checks++; if (bus.mem_addr !== 15'd0) begin errors++; $display("FAIL rst_addr got %0d exp 0", bus.mem_addr); end
      checks++; if (bus.mem_wr_data !== 162'd0) begin errors++; $display("FAIL rst_wr_data got %h exp 0", bus.mem_wr_data); end
      checks++; if (bus.q_new !== 18'sd0) begin errors++; $display("FAIL rst_q_new got %0d exp 0", bus.q_new); end
      rst = 1'b0;
   endtask

   task automatic test_terminal();
      logic [161:0] r, e;
      r = '0;
      for (int k = 0; k < 9; k++) r = put(r, k, (k + 1) * 10);
      r = put(r, 3, 0);
      e = put(r, 3, 64);
      load_row(2, r);
      do_update(0, 2, 5, 3, 256, 1, -1);
      checks++; if (o_done_c != 5) begin errors++; $display("FAIL term_done_cycle got %0d exp 5", o_done_c); end
      checks++; if (o_q !== 18'sd64) begin errors++; $display("FAIL term_q_new got %0d exp 64", o_q); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL term_err got %b exp 0", o_err); end
      checks++; if (o_rd_n != 1 || o_rd_c[0] != 1 || o_rd_a[0] != 15'd2) begin errors++; $display("FAIL term_read got n=%0d c=%0d a=%0d exp n=1 c=1 a=2", o_rd_n, o_rd_c[0], o_rd_a[0]); end
      checks++; if (o_wr_n != 1 || o_wr_c != 4 || o_wr_a != 15'd2) begin errors++; $display("FAIL term_write got n=%0d c=%0d a=%0d exp n=1 c=4 a=2", o_wr_n, o_wr_c, o_wr_a); end
      checks++; if (o_wr_d !== e) begin errors++; $display("FAIL term_wr_data got %h exp %h", o_wr_d, e); end
      checks++; if (o_busy_bad != 0) begin errors++; $display("FAIL term_busy got %0d bad cycles exp 0", o_busy_bad); end
   endtask

   task automatic test_nonterminal();
      load_row(5, put(162'd0, 4, 512));
      load_row(1, '0);
      do_update(0, 1, 5, 0, 0, 0, -1);
      checks++; if (o_done_c != 16) begin errors++; $display("FAIL nt_done_cycle got %0d exp 16", o_done_c); end
      checks++; if (o_q !== 18'sd112) begin errors++; $display("FAIL nt_q_new got %0d exp 112", o_q); end
      checks++; if (o_rd_n != 2 || o_rd_c[0] != 1 || o_rd_a[0] != 15'd5) begin errors++; $display("FAIL nt_read_next got n=%0d c=%0d a=%0d exp n=2 c=1 a=5", o_rd_n, o_rd_c[0], o_rd_a[0]); end
      checks++; if (o_rd_c[1] != 12 || o_rd_a[1] != 15'd1) begin errors++; $display("FAIL nt_read_cur got c=%0d a=%0d exp c=12 a=1", o_rd_c[1], o_rd_a[1]); end
      checks++; if (o_wr_c != 15 || o_wr_d !== put(162'd0, 0, 112)) begin errors++; $display("FAIL nt_write got c=%0d d=%h exp c=15", o_wr_c, o_wr_d); end
      checks++; if (o_busy_bad != 0) begin errors++; $display("FAIL nt_busy got %0d bad cycles exp 0", o_busy_bad); end
   endtask

   task automatic test_neg_max();
      load_row(6, put(fill(-256), 8, -128));
      load_row(3, '0);
      do_update(0, 3, 6, 8, 0, 0, -1);
      checks++; if (o_q !== -18'sd28) begin errors++; $display("FAIL neg_q_new got %0d exp -28", o_q); end
      checks++; if (o_wr_d !== put(162'd0, 8, -28)) begin errors++; $display("FAIL neg_wr_data got %h", o_wr_d); end
   endtask

   task automatic test_overflow();
      int exp_ovf;
`ifdef Q_UPDATE_SAT_EN
      exp_ovf = 131071;
`else
      exp_ovf = -102401;
`endif
      load_row(4, put(162'd0, 2, 131071));
      load_row(7, fill(131071));
      do_update(0, 4, 0, 2, 131071, 1, -1);
      checks++; if (o_q !== 18'sd131071) begin errors++; $display("FAIL ovf_term_q got %0d exp 131071", o_q); end
      do_update(0, 4, 7, 2, 131071, 0, -1);
      checks++; if (int'(o_q) != exp_ovf) begin errors++; $display("FAIL ovf_nt_q got %0d exp %0d", o_q, exp_ovf); end
   endtask

   task automatic test_invalid_action();
      do_update(0, 2, 0, 9, 256, 1, -1);
      checks++; if (o_wr_n != 0) begin errors++; $display("FAIL inv_write got %0d strobes exp 0", o_wr_n); end
      checks++; if (o_done_c != 5 || o_err !== 1'b1) begin errors++; $display("FAIL inv_done_err got c=%0d err=%b exp c=5 err=1", o_done_c, o_err); end
      checks++; if (o_q !== 18'sd64) begin errors++; $display("FAIL inv_q_new got %0d exp 64", o_q); end
   endtask

   task automatic test_reset_mid();
      int wr0, dn;
      load_row(8, '0);
      wr0 = wr_total;
      @(negedge clk);
      bus.s_cur = 15'd8; bus.s_next = 15'd5; bus.action = 4'd1;
      bus.reward = 18'sd0; bus.terminal = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rmid_busy_done got %b%b exp 00", bus.busy, bus.done); end
      checks++; if (bus.q_new !== 18'sd0) begin errors++; $display("FAIL rmid_q_new got %0d exp 0", bus.q_new); end
      rst = 1'b0;
      dn = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.done || bus.busy) dn++;
      end
      checks++; if (wr_total != wr0 || dn != 0) begin errors++; $display("FAIL rmid_no_write got writes=%0d activity=%0d exp 0 0", wr_total - wr0, dn); end
      do_update(0, 8, 0, 1, 256, 1, -1);
      checks++; if (o_done_c != 5 || o_q !== 18'sd64 || o_wr_a != 15'd8) begin errors++; $display("FAIL rmid_after got c=%0d q=%0d a=%0d exp c=5 q=64 a=8", o_done_c, o_q, o_wr_a); end
   endtask

   task automatic test_busy_ignore();
      int act;
      do_update(0, 8, 0, 2, -512, 1, 2);
      checks++; if (o_q_mid !== 18'sd64) begin errors++; $display("FAIL busy_q_held got %0d exp 64", o_q_mid); end
      checks++; if (o_done_c != 5 || o_q !== -18'sd128 || o_rd_n != 1) begin errors++; $display("FAIL busy_ign got c=%0d q=%0d rd=%0d exp c=5 q=-128 rd=1", o_done_c, o_q, o_rd_n); end
      act = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.busy || bus.done) act++;
      end
      checks++; if (act != 0) begin errors++; $display("FAIL busy_no_queue got %0d active cycles exp 0", act); end
   endtask

   task automatic test_back_to_back();
      do_update(0, 8, 0, 3, 256, 1, -1);
      checks++; if (o_done_c != 5 || o_q !== 18'sd64) begin errors++; $display("FAIL b2b_first got c=%0d q=%0d exp c=5 q=64", o_done_c, o_q); end
      do_update(1, 8, 0, 4, -256, 1, -1);
      checks++; if (o_done_c != 5 || o_q !== -18'sd64) begin errors++; $display("FAIL b2b_second got c=%0d q=%0d exp c=5 q=-64", o_done_c, o_q); end
      checks++; if (overlap != 0) begin errors++; $display("FAIL rd_wr_overlap got %0d exp 0", overlap); end
   endtask

   initial begin
      bus.start = 1'b0; bus.s_cur = '0; bus.s_next = '0;
      bus.action = '0; bus.reward = '0; bus.terminal = 1'b0;
      test_reset();
      test_terminal();
      test_nonterminal();
      test_neg_max();
      test_overflow();
      test_invalid_action();
      test_reset_mid();
      test_busy_ignore();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
